// File: rtl/cop_rf_wport_arbiter.sv
// cop_rf_wport_arbiter: round-robin arbiter for the single CPR file write port.
// Requesters (ALU, load return, random source) are granted in rotating order.
// Wide (register-pair) results are written as two back-to-back cycles.
// Each request finishes with a one-cycle req_ready pulse.
// Writes aimed at c0 run the normal cycle sequence but never raise rf_wen.
// Optional build macro: COP_RF_ARB_FORMAL_EN compiles in a protocol checker.

module cop_rf_wport_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 4,
  parameter int DW   = 32
) (
  input  logic              vtx_clk,
  input  logic              vtx_reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_wide,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata_lo,
  input  logic [NREQ*DW-1:0] req_wdata_hi,
  output logic              rf_wen,
  output logic [AW-1:0]     rf_waddr,
  output logic [DW-1:0]     rf_wdata,
  output logic              busy,
  output logic [2:0]        grant_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } state_t;

  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  state_t          state_r;
  logic [2:0]      rr_ptr_r;
  logic [2:0]      grant_r;
  logic            wide_r;
  logic [AW-1:0]   addr_r;

  logic            pick_valid_s;
  logic [2:0]      pick_idx_s;
  logic [2:0]      next_ptr_s;
  logic            done_s;
  int              dist_s;
  int              best_s;
  logic            hit_s;

  // Requester fields padded to 8 entries so a 3-bit grant indexes them exactly.
  logic [DW-1:0]   lo_arr_s   [8];
  logic [DW-1:0]   hi_arr_s   [8];
  logic [AW-1:0]   addr_arr_s [8];
  logic            wide_arr_s [8];

  for (genvar g = 0; g < 8; g++) begin : g_pad
    if (g < NREQ) begin : g_used
      assign lo_arr_s[g]   = req_wdata_lo[g*DW +: DW];
      assign hi_arr_s[g]   = req_wdata_hi[g*DW +: DW];
      assign addr_arr_s[g] = req_addr[g*AW +: AW];
      assign wide_arr_s[g] = req_wide[g];
    end else begin : g_unused
      assign lo_arr_s[g]   = '0;
      assign hi_arr_s[g]   = '0;
      assign addr_arr_s[g] = '0;
      assign wide_arr_s[g] = 1'b0;
    end
  end

  // Round-robin pick: valid requester with the smallest rotated distance from rr_ptr.
  always_comb begin
    pick_valid_s = 1'b0;
    pick_idx_s   = 3'd0;
    best_s       = NREQ;
    dist_s       = 0;
    hit_s        = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      dist_s       = (i >= int'(rr_ptr_r)) ? (i - int'(rr_ptr_r)) : (i + NREQ - int'(rr_ptr_r));
      hit_s        = req_valid[i] && (dist_s < best_s);
      best_s       = hit_s ? dist_s : best_s;
      pick_idx_s   = hit_s ? 3'(i) : pick_idx_s;
      pick_valid_s = pick_valid_s | hit_s;
    end
  end

  // Pointer value after the current grant completes: the requester just served goes last.
  always_comb begin
    if (grant_r == 3'(NREQ - 1)) begin
      next_ptr_s = 3'd0;
    end else begin
      next_ptr_s = grant_r + 3'd1;
    end
  end

  // Arbiter FSM: accept in IDLE, write low word, optionally write high word, then release.
  always_ff @(posedge vtx_clk or posedge vtx_reset) begin
    if (vtx_reset) begin
      state_r  <= IDLE;
      rr_ptr_r <= 3'd0;
      grant_r  <= 3'd0;
      wide_r   <= 1'b0;
      addr_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_valid_s) begin
            grant_r <= pick_idx_s;
            wide_r  <= wide_arr_s[pick_idx_s];
            addr_r  <= addr_arr_s[pick_idx_s];
            state_r <= WR_LO;
          end else begin
            state_r <= IDLE;
          end
        end
        WR_LO: begin
          if (wide_r) begin
            state_r <= WR_HI;
          end else begin
            state_r  <= IDLE;
            rr_ptr_r <= next_ptr_s;
          end
        end
        WR_HI: begin
          state_r  <= IDLE;
          rr_ptr_r <= next_ptr_s;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Write-port decode from the registered state; data is steered from the live inputs.
  always_comb begin
    rf_waddr = '0;
    rf_wdata = '0;
    case (state_r)
      IDLE: begin
        rf_waddr = '0;
        rf_wdata = '0;
      end
      WR_LO: begin
        rf_waddr = wide_r ? {addr_r[AW-1:1], 1'b0} : addr_r;
        rf_wdata = lo_arr_s[grant_r];
      end
      WR_HI: begin
        rf_waddr = {addr_r[AW-1:1], 1'b1};
        rf_wdata = hi_arr_s[grant_r];
      end
      default: begin
        rf_waddr = '0;
        rf_wdata = '0;
      end
    endcase
  end

  // Handshake and status decode; c0 is hard-wired zero so its writes are suppressed.
  always_comb begin
    busy      = (state_r != IDLE);
    rf_wen    = busy && (rf_waddr != '0);
    done_s    = ((state_r == WR_LO) && !wide_r) || (state_r == WR_HI);
    req_ready = done_s ? (ONE_HOT0 << grant_r) : '0;
    grant_id  = grant_r;
  end

`ifdef COP_RF_ARB_FORMAL_EN
  cop_rf_wport_arbiter_chk #(.NREQ(NREQ), .AW(AW), .DW(DW)) u_chk (
    .vtx_clk      (vtx_clk),
    .vtx_reset    (vtx_reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wide     (req_wide),
    .req_addr     (req_addr),
    .req_wdata_lo (req_wdata_lo),
    .req_wdata_hi (req_wdata_hi),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .busy         (busy),
    .grant_id     (grant_id)
  );
`else
`endif

endmodule

`ifdef COP_RF_ARB_FORMAL_EN
// Protocol checker: output invariants and requester-side assumptions.
module cop_rf_wport_arbiter_chk #(
  parameter int NREQ = 3,
  parameter int AW   = 4,
  parameter int DW   = 32
) (
  input logic               vtx_clk,
  input logic               vtx_reset,
  input logic [NREQ-1:0]    req_valid,
  input logic [NREQ-1:0]    req_ready,
  input logic [NREQ-1:0]    req_wide,
  input logic [NREQ*AW-1:0] req_addr,
  input logic [NREQ*DW-1:0] req_wdata_lo,
  input logic [NREQ*DW-1:0] req_wdata_hi,
  input logic               rf_wen,
  input logic [AW-1:0]      rf_waddr,
  input logic               busy,
  input logic [2:0]         grant_id
);

  logic [NREQ-1:0]    pend_r;
  logic [NREQ-1:0]    wide_q_r;
  logic [NREQ*AW-1:0] addr_q_r;
  logic [NREQ*DW-1:0] lo_q_r;
  logic [NREQ*DW-1:0] hi_q_r;

  // Remember which requests were pending and unserved, with their fields.
  always_ff @(posedge vtx_clk or posedge vtx_reset) begin
    if (vtx_reset) begin
      pend_r   <= '0;
      wide_q_r <= '0;
      addr_q_r <= '0;
      lo_q_r   <= '0;
      hi_q_r   <= '0;
    end else begin
      pend_r   <= req_valid & ~req_ready;
      wide_q_r <= req_wide;
      addr_q_r <= req_addr;
      lo_q_r   <= req_wdata_lo;
      hi_q_r   <= req_wdata_hi;
    end
  end

  // Immediate invariants and assumptions sampled on the clock.
  always @(posedge vtx_clk) begin
    if (!vtx_reset) begin
      assert ($countones(req_ready) <= 1);
      assert (busy || !rf_wen);
      assert (!(rf_wen && (rf_waddr == '0)));
      assert (int'(grant_id) < NREQ);
      for (int i = 0; i < NREQ; i++) begin
        if (pend_r[i] && req_valid[i]) begin
          assume (req_wide[i] == wide_q_r[i]);
          assume (req_addr[i*AW +: AW] == addr_q_r[i*AW +: AW]);
          assume (req_wdata_lo[i*DW +: DW] == lo_q_r[i*DW +: DW]);
          assume (req_wdata_hi[i*DW +: DW] == hi_q_r[i*DW +: DW]);
        end
        if (req_valid[i] && req_wide[i]) begin
          assume (req_addr[i*AW] == 1'b0);
        end
      end
    end
  end

endmodule
`endif

// File: tb/tb_cop_rf_wport_arbiter.sv
// Self-checking bench for cop_rf_wport_arbiter: directed scenarios plus a
// randomized run against a transaction-level round-robin model.

module tb_cop_rf_wport_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 4;
  localparam int DW   = 32;

  logic              vtx_clk = 1'b0;
  logic              vtx_reset = 1'b1;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_wide;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata_lo;
  logic [NREQ*DW-1:0] req_wdata_hi;
  logic              rf_wen;
  logic [AW-1:0]     rf_waddr;
  logic [DW-1:0]     rf_wdata;
  logic              busy;
  logic [2:0]        grant_id;

  int checks = 0;
  int errors = 0;

  // Observation word: {busy, rf_wen, rf_waddr, rf_wdata, req_ready}
  logic [40:0] obs;
  assign obs = {busy, rf_wen, rf_waddr, rf_wdata, req_ready};

  typedef struct packed {
    logic [40:0] o;
    logic [2:0]  g;
  } beat_t;

  beat_t exp_q[$];

  cop_rf_wport_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .vtx_clk      (vtx_clk),
    .vtx_reset    (vtx_reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wide     (req_wide),
    .req_addr     (req_addr),
    .req_wdata_lo (req_wdata_lo),
    .req_wdata_hi (req_wdata_hi),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  always #5 vtx_clk = ~vtx_clk;

  task clear_inputs;
    req_valid    = '0;
    req_wide     = '0;
    req_addr     = '0;
    req_wdata_lo = '0;
    req_wdata_hi = '0;
  endtask

  task set_req(input int i, input logic w, input logic [3:0] a, input logic [31:0] l, input logic [31:0] h);
    req_valid[i]           = 1'b1;
    req_wide[i]            = w;
    req_addr[i*AW +: AW]   = a;
    req_wdata_lo[i*DW +: DW] = l;
    req_wdata_hi[i*DW +: DW] = h;
  endtask

  task apply_reset;
    @(negedge vtx_clk);
    vtx_reset = 1'b1;
    clear_inputs();
    @(negedge vtx_clk);
    vtx_reset = 1'b0;
  endtask

  task test_reset;
    clear_inputs();
    req_valid = 3'b111;
    repeat (2) @(negedge vtx_clk);
    checks++;
    if (obs !== 41'd0 || grant_id !== 3'd0) begin
      errors++;
      $display("FAIL reset_state got obs=%h grant=%0d want obs=0 grant=0", obs, grant_id);
    end
    clear_inputs();
    vtx_reset = 1'b0;
    @(negedge vtx_clk);
  endtask

  task test_narrow;
    set_req(0, 1'b0, 4'd5, 32'hDEADBEEF, 32'h0);
    @(negedge vtx_clk);
    checks++;
    if (obs !== {1'b1, 1'b1, 4'd5, 32'hDEADBEEF, 3'b001} || grant_id !== 3'd0) begin
      errors++;
      $display("FAIL narrow_write got obs=%h grant=%0d", obs, grant_id);
    end
    clear_inputs();
    @(negedge vtx_clk);
    checks++;
    if (obs !== 41'd0) begin
      errors++;
      $display("FAIL narrow_bubble got obs=%h want 0", obs);
    end
  endtask

  task test_wide;
    set_req(1, 1'b1, 4'd6, 32'h11111111, 32'h22222222);
    @(negedge vtx_clk);
    checks++;
    if (obs !== {1'b1, 1'b1, 4'd6, 32'h11111111, 3'b000} || grant_id !== 3'd1) begin
      errors++;
      $display("FAIL wide_lo got obs=%h grant=%0d", obs, grant_id);
    end
    @(negedge vtx_clk);
    checks++;
    if (obs !== {1'b1, 1'b1, 4'd7, 32'h22222222, 3'b010}) begin
      errors++;
      $display("FAIL wide_hi got obs=%h", obs);
    end
    clear_inputs();
    @(negedge vtx_clk);
    checks++;
    if (obs !== 41'd0) begin
      errors++;
      $display("FAIL wide_bubble got obs=%h want 0", obs);
    end
  endtask

  task test_all_valid;
    logic [2:0] g;
    @(negedge vtx_clk);
    vtx_reset = 1'b1;
    clear_inputs();
    for (int r = 0; r < NREQ; r++) set_req(r, 1'b0, 4'(r + 1), 32'hA0000000 + 32'(r), 32'h0);
    @(negedge vtx_clk);
    vtx_reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      g = 3'(k % NREQ);
      @(negedge vtx_clk);
      checks++;
      if (obs !== {1'b1, 1'b1, 4'(g + 3'd1), 32'hA0000000 + 32'(g), 3'b001 << g} || grant_id !== g) begin
        errors++;
        $display("FAIL rr_order k=%0d got obs=%h grant=%0d want grant=%0d", k, obs, grant_id, g);
      end
      @(negedge vtx_clk);
      checks++;
      if (busy !== 1'b0 || req_ready !== 3'b000) begin
        errors++;
        $display("FAIL rr_bubble k=%0d got busy=%b ready=%b", k, busy, req_ready);
      end
    end
    clear_inputs();
  endtask

  task test_c0;
    apply_reset();
    set_req(0, 1'b0, 4'd0, 32'hCAFEF00D, 32'h0);
    @(negedge vtx_clk);
    checks++;
    if (obs !== {1'b1, 1'b0, 4'd0, 32'hCAFEF00D, 3'b001}) begin
      errors++;
      $display("FAIL c0_write got obs=%h", obs);
    end
    clear_inputs();
    @(negedge vtx_clk);
    checks++;
    if (obs !== 41'd0) begin
      errors++;
      $display("FAIL c0_bubble got obs=%h want 0", obs);
    end
  endtask

  task test_reset_mid_wide;
    set_req(2, 1'b1, 4'd10, 32'h0A0A0A0A, 32'h0B0B0B0B);
    @(negedge vtx_clk);
    checks++;
    if (obs !== {1'b1, 1'b1, 4'd10, 32'h0A0A0A0A, 3'b000} || grant_id !== 3'd2) begin
      errors++;
      $display("FAIL midrst_lo got obs=%h grant=%0d", obs, grant_id);
    end
    @(posedge vtx_clk);
    #2;
    vtx_reset = 1'b1;
    #1;
    checks++;
    if (obs !== 41'd0 || grant_id !== 3'd0) begin
      errors++;
      $display("FAIL midrst_out got obs=%h grant=%0d want 0", obs, grant_id);
    end
    @(negedge vtx_clk);
    clear_inputs();
    vtx_reset = 1'b0;
    set_req(0, 1'b0, 4'd3, 32'h0C0C0C0C, 32'h0);
    set_req(1, 1'b0, 4'd4, 32'h0D0D0D0D, 32'h0);
    @(negedge vtx_clk);
    checks++;
    if (obs !== {1'b1, 1'b1, 4'd3, 32'h0C0C0C0C, 3'b001}) begin
      errors++;
      $display("FAIL midrst_ptr got obs=%h", obs);
    end
    req_valid[0] = 1'b0;
    @(negedge vtx_clk);
    @(negedge vtx_clk);
    checks++;
    if (obs !== {1'b1, 1'b1, 4'd4, 32'h0D0D0D0D, 3'b010}) begin
      errors++;
      $display("FAIL midrst_next got obs=%h", obs);
    end
    clear_inputs();
    @(negedge vtx_clk);
  endtask

  task test_wide_odd;
    set_req(1, 1'b1, 4'd9, 32'h0E0E0E0E, 32'h0F0F0F0F);
    @(negedge vtx_clk);
    checks++;
    if (obs !== {1'b1, 1'b1, 4'd8, 32'h0E0E0E0E, 3'b000}) begin
      errors++;
      $display("FAIL odd_lo got obs=%h", obs);
    end
    @(negedge vtx_clk);
    checks++;
    if (obs !== {1'b1, 1'b1, 4'd9, 32'h0F0F0F0F, 3'b010}) begin
      errors++;
      $display("FAIL odd_hi got obs=%h", obs);
    end
    clear_inputs();
    @(negedge vtx_clk);
  endtask

  task new_req(input int r);
    logic [3:0] a;
    a = ($urandom % 5 == 0) ? 4'($urandom % 2) : 4'($urandom);
    set_req(r, 1'($urandom), a, $urandom, $urandom);
  endtask

  task test_random;
    beat_t      b;
    logic [2:0] done;
    logic       idle;
    int         start;
    int         served [NREQ];
    logic       found;
    logic [3:0] a;
    logic [3:0] base;
    apply_reset();
    exp_q.delete();
    start = 0;
    for (int r = 0; r < NREQ; r++) served[r] = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge vtx_clk);
      done = 3'b000;
      idle = (exp_q.size() == 0);
      checks++;
      if (!idle) begin
        b = exp_q.pop_front();
        done = b.o[2:0];
        if (obs !== b.o || grant_id !== b.g) begin
          errors++;
          $display("FAIL rand_beat cyc=%0d got obs=%h grant=%0d want obs=%h grant=%0d", cyc, obs, grant_id, b.o, b.g);
        end
      end else begin
        if (obs !== 41'd0) begin
          errors++;
          $display("FAIL rand_idle cyc=%0d got obs=%h want 0", cyc, obs);
        end
      end
      for (int r = 0; r < NREQ; r++) begin
        if (done[r]) begin
          served[r]++;
          if ($urandom % 2 == 0) new_req(r);
          else req_valid[r] = 1'b0;
        end else if (!req_valid[r] && ($urandom % 3 == 0)) begin
          new_req(r);
        end
      end
      if (idle) begin
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
          int c;
          c = (start + k) % NREQ;
          if (!found && req_valid[c]) begin
            found = 1'b1;
            a = req_addr[c*AW +: AW];
            if (!req_wide[c]) begin
              exp_q.push_back('{o: {1'b1, (a != 4'd0), a, req_wdata_lo[c*DW +: DW], 3'b001 << c}, g: 3'(c)});
            end else begin
              base = {a[3:1], 1'b0};
              exp_q.push_back('{o: {1'b1, (base != 4'd0), base, req_wdata_lo[c*DW +: DW], 3'b000}, g: 3'(c)});
              exp_q.push_back('{o: {1'b1, 1'b1, base | 4'd1, req_wdata_hi[c*DW +: DW], 3'b001 << c}, g: 3'(c)});
            end
            start = (c + 1) % NREQ;
          end
        end
      end
    end
    for (int r = 0; r < NREQ; r++) begin
      checks++;
      if (served[r] == 0) begin
        errors++;
        $display("FAIL rand_starve req=%0d got 0 completions want >0", r);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_narrow();
    test_wide();
    test_all_valid();
    test_c0();
    test_reset_mid_wide();
    test_wide_odd();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
